// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Brief    : Shared state/grant encodings and defaults for the memory arbiter.
//  Revision : 1.0
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } gnt_t;

  localparam int         c_TIMEOUT_CYCLES_DEFAULT = 255;
  localparam logic [3:0] c_FETCH_MASK             = 4'hF;

endpackage
`default_nettype wire

// File: rtl/mem_arb_wdog.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_wdog
//  Brief    : Memory response watchdog; flags expiry after LIMIT busy cycles.
//  Revision : 1.0
// ============================================================================
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = c_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int                 c_WIDTH = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [c_WIDTH-1:0] c_LAST  = c_WIDTH'(LIMIT - 1);

  logic [c_WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_en && !expired) begin
      r_count <= r_count + c_WIDTH'(1);
    end
  end

  // Expires during the LIMIT-th busy cycle so RESP follows immediately.
  assign expired = count_en && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Round-robin fetch/data arbiter onto one shared memory port.
//             Define MEM_ARB_TIMEOUT_EN to add the response watchdog/op_mem_err.
//  Revision : 1.0
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ip_inst_rd,
  input  logic [31:0] ip_inst_addr,
  output logic        op_inst_valid,
  output logic [31:0] op_inst_data,
  input  logic        ip_data_rd,
  input  logic        ip_data_wr,
  input  logic [31:0] ip_data_addr,
  input  logic [3:0]  ip_data_mask,
  input  logic [31:0] ip_data_wdata,
  output logic        op_data_valid,
  output logic [31:0] op_data_rdata,
  output logic        op_mem_rd,
  output logic        op_mem_wr,
  output logic [31:0] op_mem_addr,
  output logic [3:0]  op_mem_mask,
  output logic [31:0] op_mem_wdata,
  input  logic        ip_mem_valid,
  input  logic [31:0] ip_mem_rdata
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic        op_mem_err
`endif
);

  state_t      r_state;
  state_t      w_state_next;
  gnt_t        r_last_gnt;
  gnt_t        w_gnt_sel;
  logic        w_grant;
  logic        w_resp_load;
  logic        w_timeout_hit;
  logic        w_busy;
  logic        w_data_req;
  logic        w_expired;
  logic [31:0] w_resp_word;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;
  logic        r_rd;
  logic        r_wr;
  logic [31:0] r_inst_data;
  logic [31:0] r_data_rdata;

  assign w_data_req = ip_data_rd | ip_data_wr;
  assign w_busy     = (r_state == INST) || (r_state == DATA);

`ifdef MEM_ARB_TIMEOUT_EN
  logic r_mem_err;

  mem_arb_wdog #(
    .LIMIT   (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_grant),
    .count_en(w_busy),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_err <= 1'b0;
    end else begin
      r_mem_err <= w_timeout_hit;
    end
  end

  assign op_mem_err = r_mem_err;
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_grant       = 1'b0;
    w_gnt_sel     = r_last_gnt;
    w_resp_load   = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      IDLE: begin
        // On contention the requester that did not win last time goes first.
        if (w_data_req && ip_inst_rd) begin
          w_grant   = 1'b1;
          w_gnt_sel = (r_last_gnt == GNT_INST) ? GNT_DATA : GNT_INST;
        end else if (w_data_req) begin
          w_grant   = 1'b1;
          w_gnt_sel = GNT_DATA;
        end else if (ip_inst_rd) begin
          w_grant   = 1'b1;
          w_gnt_sel = GNT_INST;
        end
        if (w_grant) begin
          w_state_next = (w_gnt_sel == GNT_DATA) ? DATA : INST;
        end
      end
      INST, DATA: begin
        if (ip_mem_valid) begin
          w_resp_load  = 1'b1;
          w_state_next = RESP;
        end else if (w_expired) begin
          w_timeout_hit = 1'b1;
          w_state_next  = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request is frozen into the holding registers at the grant edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_gnt <= GNT_INST;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mask     <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
    end else if (w_grant) begin
      r_last_gnt <= w_gnt_sel;
      if (w_gnt_sel == GNT_DATA) begin
        r_addr  <= ip_data_addr;
        r_wdata <= ip_data_wdata;
        r_mask  <= ip_data_mask;
        r_rd    <= ip_data_rd;
        r_wr    <= ip_data_wr;
      end else begin
        r_addr  <= ip_inst_addr;
        r_wdata <= '0;
        r_mask  <= c_FETCH_MASK;
        r_rd    <= 1'b1;
        r_wr    <= 1'b0;
      end
    end
  end

  // Writes and timeouts return a zero word.
  assign w_resp_word = (w_timeout_hit || r_wr) ? 32'h0 : ip_mem_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inst_data  <= '0;
      r_data_rdata <= '0;
    end else if (w_resp_load || w_timeout_hit) begin
      if (r_last_gnt == GNT_INST) begin
        r_inst_data <= w_resp_word;
      end else begin
        r_data_rdata <= w_resp_word;
      end
    end
  end

  assign op_inst_valid = (r_state == RESP) && (r_last_gnt == GNT_INST);
  assign op_data_valid = (r_state == RESP) && (r_last_gnt == GNT_DATA);
  assign op_inst_data  = r_inst_data;
  assign op_data_rdata = r_data_rdata;

  assign op_mem_rd    = w_busy & r_rd;
  assign op_mem_wr    = w_busy & r_wr;
  assign op_mem_mask  = w_busy ? r_mask : 4'h0;
  assign op_mem_addr  = r_addr;
  assign op_mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Self-checking bench for mem_arbiter against a transaction model.
//  Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int TMO = 8;

  logic        clk;
  logic        reset_n;
  logic        ip_inst_rd;
  logic [31:0] ip_inst_addr;
  logic        op_inst_valid;
  logic [31:0] op_inst_data;
  logic        ip_data_rd;
  logic        ip_data_wr;
  logic [31:0] ip_data_addr;
  logic [3:0]  ip_data_mask;
  logic [31:0] ip_data_wdata;
  logic        op_data_valid;
  logic [31:0] op_data_rdata;
  logic        op_mem_rd;
  logic        op_mem_wr;
  logic [31:0] op_mem_addr;
  logic [3:0]  op_mem_mask;
  logic [31:0] op_mem_wdata;
  logic        ip_mem_valid;
  logic [31:0] ip_mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        op_mem_err;
`endif

  mem_arbiter #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ip_inst_rd   (ip_inst_rd),
    .ip_inst_addr (ip_inst_addr),
    .op_inst_valid(op_inst_valid),
    .op_inst_data (op_inst_data),
    .ip_data_rd   (ip_data_rd),
    .ip_data_wr   (ip_data_wr),
    .ip_data_addr (ip_data_addr),
    .ip_data_mask (ip_data_mask),
    .ip_data_wdata(ip_data_wdata),
    .op_data_valid(op_data_valid),
    .op_data_rdata(op_data_rdata),
    .op_mem_rd    (op_mem_rd),
    .op_mem_wr    (op_mem_wr),
    .op_mem_addr  (op_mem_addr),
    .op_mem_mask  (op_mem_mask),
    .op_mem_wdata (op_mem_wdata),
    .ip_mem_valid (ip_mem_valid),
    .ip_mem_rdata (ip_mem_rdata)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .op_mem_err   (op_mem_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Requester-side model: what each requester is asking for right now.
  logic        inst_pend, data_pend, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_mask;
  bit          last_was_data;
  logic [31:0] exp_inst_data, exp_data_rdata;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reqs();
    ip_inst_rd    = inst_pend;
    ip_inst_addr  = i_addr;
    ip_data_rd    = data_pend && !d_wr;
    ip_data_wr    = data_pend && d_wr;
    ip_data_addr  = d_addr;
    ip_data_mask  = d_mask;
    ip_data_wdata = d_wdata;
  endtask

  task automatic new_inst();
    i_addr    = $urandom & 32'h7FFF_FFFC;
    inst_pend = 1'b1;
  endtask

  task automatic new_data();
    d_addr    = $urandom | 32'h8000_0000;
    d_wr      = 1'($urandom_range(0, 1));
    d_mask    = 4'($urandom_range(1, 15));
    d_wdata   = $urandom;
    data_pend = 1'b1;
  endtask

  // Called in an IDLE cycle with requests applied; returns in the following IDLE cycle.
  task automatic run_txn(input int waits, input logic [31:0] rdata, input bit silent);
    bit          win_data;
    int          n;
    logic        ex_rd, ex_wr;
    logic [3:0]  ex_mask;
    logic [31:0] ex_addr, ex_wdata, ex_resp;
    win_data = (inst_pend && data_pend) ? !last_was_data : data_pend;
    if (win_data) begin
      ex_rd = !d_wr; ex_wr = d_wr; ex_mask = d_mask; ex_addr = d_addr; ex_wdata = d_wdata;
    end else begin
      ex_rd = 1'b1; ex_wr = 1'b0; ex_mask = 4'hF; ex_addr = i_addr; ex_wdata = 32'h0;
    end
    ex_resp = (silent || ex_wr) ? 32'h0 : rdata;
    n = silent ? TMO : waits + 1;
    tick();
    for (int i = 0; i < n; i++) begin
      check_eq("mem_bus", {op_mem_rd, op_mem_wr, op_mem_mask, op_mem_addr, op_mem_wdata},
               {ex_rd, ex_wr, ex_mask, ex_addr, ex_wdata});
      check_eq("busy_valid", {op_inst_valid, op_data_valid}, 2'b00);
      ip_mem_valid = (i == n - 1) && !silent;
      ip_mem_rdata = ip_mem_valid ? rdata : $urandom;
      // The granted requester's inputs may wander; the transfer must not notice.
      if (win_data) begin
        ip_data_addr  = $urandom;
        ip_data_mask  = 4'($urandom);
        ip_data_wdata = $urandom;
      end else begin
        ip_inst_addr = $urandom;
      end
      tick();
    end
    if (win_data) begin
      exp_data_rdata = ex_resp; data_pend = 1'b0;
    end else begin
      exp_inst_data = ex_resp; inst_pend = 1'b0;
    end
    check_eq("resp_valid", {op_inst_valid, op_data_valid}, {!win_data, win_data});
    check_eq("resp_data", {op_inst_data, op_data_rdata}, {exp_inst_data, exp_data_rdata});
    check_eq("resp_bus", {op_mem_rd, op_mem_wr, op_mem_mask, op_mem_addr, op_mem_wdata},
             {6'b0, ex_addr, ex_wdata});
`ifdef MEM_ARB_TIMEOUT_EN
    check_eq("resp_err", op_mem_err, silent);
`endif
    last_was_data = win_data;
    apply_reqs();
    ip_mem_valid = 1'($urandom_range(0, 1));
    ip_mem_rdata = $urandom;
    tick();
    check_eq("idle_valid", {op_inst_valid, op_data_valid}, 2'b00);
    check_eq("idle_held", {op_inst_data, op_data_rdata}, {exp_inst_data, exp_data_rdata});
    check_eq("idle_bus", {op_mem_rd, op_mem_wr, op_mem_mask, op_mem_addr, op_mem_wdata},
             {6'b0, ex_addr, ex_wdata});
`ifdef MEM_ARB_TIMEOUT_EN
    check_eq("idle_err", op_mem_err, 1'b0);
`endif
    ip_mem_valid = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    inst_pend = 1'b0; data_pend = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_mask = '0;
    last_was_data = 1'b0; exp_inst_data = '0; exp_data_rdata = '0;
    ip_mem_valid = 1'b0; ip_mem_rdata = '0;
    apply_reqs();

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ctl", {op_inst_valid, op_data_valid, op_mem_rd, op_mem_wr, op_mem_mask}, 8'h0);
    check_eq("rst_bus", {op_mem_addr, op_mem_wdata}, 64'h0);
    check_eq("rst_rsp", {op_inst_data, op_data_rdata}, 64'h0);
    #3 reset_n = 1'b1;

    // Zero-wait fetch: strobe in cycle 1, valid in cycle 2.
    i_addr = 32'h0000_0100; inst_pend = 1'b1; apply_reqs();
    run_txn(0, 32'h0050_0093, 1'b0);

    // Store with three wait states returns a zero word.
    ip_mem_valid = 1'b0;
    data_pend = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_2002; d_mask = 4'b1100; d_wdata = 32'hBEEF_0000;
    apply_reqs();
    run_txn(3, 32'hDEAD_BEEF, 1'b0);

    // Reset while a load is waiting in DATA.
    ip_mem_valid = 1'b0;
    new_data(); d_wr = 1'b0; apply_reqs();
    tick();
    check_eq("pre_rst_rd", {op_mem_rd, op_mem_addr}, {1'b1, d_addr});
    tick();
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_ctl", {op_inst_valid, op_data_valid, op_mem_rd, op_mem_wr, op_mem_mask}, 8'h0);
    check_eq("arst_bus", {op_mem_addr, op_mem_wdata}, 64'h0);
    check_eq("arst_rsp", {op_inst_data, op_data_rdata}, 64'h0);
    data_pend = 1'b0; apply_reqs();
    exp_inst_data = '0; exp_data_rdata = '0; last_was_data = 1'b0;
    ip_mem_valid = 1'b1; ip_mem_rdata = 32'h1234_5678;
    @(posedge clk);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("late_valid", {op_inst_valid, op_data_valid, op_mem_rd, op_mem_wr}, 4'h0);
    end
    ip_mem_valid = 1'b0;

    // Four back-to-back contentions after reset: data, inst, data, inst.
    new_inst(); new_data(); apply_reqs();
    for (int k = 0; k < 4; k++) begin
      run_txn($urandom_range(0, 2), $urandom, 1'b0);
      if (last_was_data) new_data(); else new_inst();
      apply_reqs();
    end
    run_txn($urandom_range(0, 2), $urandom, 1'b0);
    run_txn($urandom_range(0, 2), $urandom, 1'b0);

    // Randomized mix of arrivals, wait states and request types.
    for (int k = 0; k < 60; k++) begin
      if (!inst_pend && ($urandom_range(0, 1) == 1)) new_inst();
      if (!data_pend && ($urandom_range(0, 1) == 1)) new_data();
      if (!inst_pend && !data_pend) new_inst();
      apply_reqs();
      run_txn($urandom_range(0, 3), $urandom, 1'b0);
    end
    if (inst_pend || data_pend) run_txn($urandom_range(0, 3), $urandom, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Silent memory: RESP after TMO strobe cycles with error and zero data.
    ip_mem_valid = 1'b0;
    new_data(); d_wr = 1'b0; apply_reqs();
    run_txn(0, 32'hFFFF_FFFF, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
